// File: rtl/req_arb4_rr_pkg.sv
// Shared definitions for the 4-way round-robin arbiter: sizes, FSM states, one-hot helper.
// Pure declarations; no timing or flow-control behaviour of its own.
// Imported by req_arb4_rr and rr_pick4.
package req_arb4_rr_pkg;

    localparam int NREQ = 4;
    localparam int IDW  = 2;
    localparam int CNTW = 8;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_OWN  = 1'b1
    } arb_state_t;

    function automatic logic [NREQ-1:0] onehot(input logic [IDW-1:0] idx);
        logic [NREQ-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/req_arb4_rr_pick4.sv
// Rotating-priority encoder: first set request after 'last', wrapping mod 4.
// Latency: combinational.
// Backpressure: none; the caller decides when the pick is taken.
module rr_pick4
    import req_arb4_rr_pkg::*;
(
    input  logic [NREQ-1:0] req,
    input  logic [IDW-1:0]  last,
    output logic [IDW-1:0]  pick,
    output logic            vld
);

    logic [IDW-1:0] idx;

    // Walk from farthest (last+4 == last) to nearest (last+1) so the nearest hit wins.
    always_comb begin
        pick = last;
        vld  = 1'b0;
        idx  = '0;
        for (int i = NREQ; i >= 1; i--) begin
            idx = last + IDW'(i);
            if (req[idx]) begin
                pick = idx;
                vld  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/req_arb4_rr.sv
// 4-way round-robin arbiter with one-hot grant held until DONE or request drop; ARB4_TIMEOUT_EN adds forced release.
// Latency: REQ -> GNT one clock; release -> GNT low one clock; always >=1 idle cycle between grants.
// Backpressure: waiting requesters hold REQ; the owner is never preempted except by timeout.
module req_arb4_rr
    import req_arb4_rr_pkg::*;
#(
    parameter int HOLD_MAX = 15
) (
    input  logic       C,
    input  logic       CLR,
    input  logic [3:0] REQ,
    input  logic       DONE,
    output logic [3:0] GNT,
    output logic [1:0] GID,
    output logic       BUSY,
    output logic       ANY,
    output logic       TO
);

    if (HOLD_MAX < 1 || HOLD_MAX > 255) begin : g_bad_hold
        $error("HOLD_MAX must be in 1..255");
    end

    arb_state_t     state;
    arb_state_t     state_nxt;
    logic [IDW-1:0] last;
    logic [IDW-1:0] pick;
    logic           pick_vld;
    logic           grant_now;
    logic           rel_now;
    logic           timeout_now;

`ifdef ARB4_TIMEOUT_EN
    localparam logic [CNTW-1:0] HOLD_LAST = CNTW'(HOLD_MAX - 1);
    logic [CNTW-1:0] hold_cnt;
`endif

    rr_pick4 u_pick (
        .req  (REQ),
        .last (last),
        .pick (pick),
        .vld  (pick_vld)
    );

    assign ANY  = |REQ;
    assign BUSY = (state == ST_OWN);

    always_comb begin
        state_nxt   = state;
        grant_now   = 1'b0;
        rel_now     = 1'b0;
        timeout_now = 1'b0;
        case (state)
            ST_IDLE: begin
                if (pick_vld) begin
                    grant_now = 1'b1;
                    state_nxt = ST_OWN;
                end
            end
            ST_OWN: begin
                // Normal release is checked first so it masks a coincident timeout.
                if (DONE || !REQ[GID]) begin
                    rel_now   = 1'b1;
                    state_nxt = ST_IDLE;
                end
`ifdef ARB4_TIMEOUT_EN
                else if (hold_cnt == HOLD_LAST) begin
                    rel_now     = 1'b1;
                    timeout_now = 1'b1;
                    state_nxt   = ST_IDLE;
                end
`endif
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge C or posedge CLR) begin
        if (CLR) begin
            state <= ST_IDLE;
            GNT   <= '0;
            GID   <= '0;
            last  <= 2'd3;
        end else begin
            state <= state_nxt;
            if (grant_now) begin
                GNT  <= onehot(pick);
                GID  <= pick;
                last <= pick;
            end else if (rel_now) begin
                GNT <= '0;
            end
        end
    end

`ifdef ARB4_TIMEOUT_EN
    always_ff @(posedge C or posedge CLR) begin
        if (CLR) begin
            hold_cnt <= '0;
            TO       <= 1'b0;
        end else begin
            TO <= timeout_now;
            if (grant_now) begin
                hold_cnt <= '0;
            end else if (state == ST_OWN) begin
                hold_cnt <= hold_cnt + CNTW'(1);
            end
        end
    end
`else
    assign TO = 1'b0;
`endif

endmodule

// File: tb/tb_req_arb4_rr.sv
// Directed and randomized checks of req_arb4_rr; timeout scenario selected by ARB4_TIMEOUT_EN.
module tb_req_arb4_rr;

`ifdef ARB4_TIMEOUT_EN
    localparam int HM = 4;
`else
    localparam int HM = 15;
`endif

    logic       C;
    logic       CLR;
    logic [3:0] REQ;
    logic       DONE;
    logic [3:0] GNT;
    logic [1:0] GID;
    logic       BUSY;
    logic       ANY;
    logic       TO;

    int n_cmp = 0;
    int n_err = 0;

    req_arb4_rr #(.HOLD_MAX(HM)) dut (
        .C    (C),
        .CLR  (CLR),
        .REQ  (REQ),
        .DONE (DONE),
        .GNT  (GNT),
        .GID  (GID),
        .BUSY (BUSY),
        .ANY  (ANY),
        .TO   (TO)
    );

    initial C = 1'b0;
    always #5 C = ~C;

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog expired");
    end

    task automatic test_reset;
        #2;
        n_cmp++; if (GNT !== 4'b0000) begin n_err++; $display("FAIL reset_gnt: got %b want 0000", GNT); end
        n_cmp++; if (GID !== 2'd0) begin n_err++; $display("FAIL reset_gid: got %0d want 0", GID); end
        n_cmp++; if (BUSY !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", BUSY); end
        n_cmp++; if (TO !== 1'b0) begin n_err++; $display("FAIL reset_to: got %b want 0", TO); end
        REQ = 4'b0101;
        #1;
        n_cmp++; if (ANY !== 1'b1) begin n_err++; $display("FAIL any_in_reset: got %b want 1", ANY); end
        REQ = 4'b0000;
        #1;
        n_cmp++; if (ANY !== 1'b0) begin n_err++; $display("FAIL any_zero: got %b want 0", ANY); end
        @(negedge C);
        CLR = 1'b0;
    endtask

    task automatic test_fairness;
        logic [3:0] exp_g [0:8];
        exp_g = '{4'b0001, 4'b0000, 4'b0010, 4'b0000, 4'b0100, 4'b0000, 4'b1000, 4'b0000, 4'b0001};
        @(negedge C);
        CLR = 1'b1;
        #1;
        CLR  = 1'b0;
        REQ  = 4'b1111;
        DONE = 1'b0;
        for (int k = 0; k < 9; k++) begin
            @(negedge C);
            n_cmp++;
            if (GNT !== exp_g[k]) begin
                n_err++;
                $display("FAIL fair_seq[%0d]: got %b want %b", k, GNT, exp_g[k]);
            end
            DONE = (exp_g[k] != 4'b0000);
        end
        @(negedge C);
        REQ  = 4'b0000;
        DONE = 1'b0;
        @(negedge C);
    endtask

    task automatic test_clr_mid_grant;
        REQ  = 4'b0100;
        DONE = 1'b0;
        @(negedge C);
        n_cmp++; if (GNT !== 4'b0100) begin n_err++; $display("FAIL clr_pre_gnt: got %b want 0100", GNT); end
        #2;
        CLR = 1'b1;
        #1;
        n_cmp++; if (GNT !== 4'b0000) begin n_err++; $display("FAIL clr_async_gnt: got %b want 0000", GNT); end
        n_cmp++; if (BUSY !== 1'b0) begin n_err++; $display("FAIL clr_async_busy: got %b want 0", BUSY); end
        #1;
        CLR = 1'b0;
        REQ = 4'b1111;
        @(negedge C);
        n_cmp++; if (GNT !== 4'b0001) begin n_err++; $display("FAIL clr_restart_gnt: got %b want 0001", GNT); end
        n_cmp++; if (GID !== 2'd0) begin n_err++; $display("FAIL clr_restart_gid: got %0d want 0", GID); end
        DONE = 1'b1;
        REQ  = 4'b0000;
        @(negedge C);
        DONE = 1'b0;
        n_cmp++; if (GNT !== 4'b0000) begin n_err++; $display("FAIL clr_release: got %b want 0000", GNT); end
    endtask

    task automatic test_single;
        REQ = 4'b0100;
        @(negedge C);
        n_cmp++; if (GNT !== 4'b0100) begin n_err++; $display("FAIL single_gnt: got %b want 0100", GNT); end
        n_cmp++; if (GID !== 2'd2) begin n_err++; $display("FAIL single_gid: got %0d want 2", GID); end
        n_cmp++; if (BUSY !== 1'b1) begin n_err++; $display("FAIL single_busy: got %b want 1", BUSY); end
        REQ = 4'b0000;
        @(negedge C);
        n_cmp++; if (GNT !== 4'b0000) begin n_err++; $display("FAIL drop_gnt: got %b want 0000", GNT); end
        n_cmp++; if (BUSY !== 1'b0) begin n_err++; $display("FAIL drop_busy: got %b want 0", BUSY); end
    endtask

    task automatic test_done_plus_req;
        REQ = 4'b0010;
        @(negedge C);
        n_cmp++; if (GNT !== 4'b0010) begin n_err++; $display("FAIL own1_gnt: got %b want 0010", GNT); end
        n_cmp++; if (GID !== 2'd1) begin n_err++; $display("FAIL own1_gid: got %0d want 1", GID); end
        REQ = 4'b1010;
        @(negedge C);
        n_cmp++; if (GNT !== 4'b0010) begin n_err++; $display("FAIL no_preempt: got %b want 0010", GNT); end
        REQ  = 4'b1011;
        DONE = 1'b1;
        @(negedge C);
        n_cmp++; if (GNT !== 4'b0000) begin n_err++; $display("FAIL done_release: got %b want 0000", GNT); end
        n_cmp++; if (BUSY !== 1'b0) begin n_err++; $display("FAIL done_busy: got %b want 0", BUSY); end
        DONE = 1'b0;
        REQ  = 4'b1001;
        @(negedge C);
        n_cmp++; if (GNT !== 4'b1000) begin n_err++; $display("FAIL rotate_gnt: got %b want 1000", GNT); end
        n_cmp++; if (GID !== 2'd3) begin n_err++; $display("FAIL rotate_gid: got %0d want 3", GID); end
        DONE = 1'b1;
        REQ  = 4'b0000;
        @(negedge C);
        DONE = 1'b0;
        n_cmp++; if (GNT !== 4'b0000) begin n_err++; $display("FAIL rotate_release: got %b want 0000", GNT); end
    endtask

    task automatic test_idle_inputs;
        DONE = 1'b1;
        REQ  = 4'b0000;
        @(negedge C);
        @(negedge C);
        DONE = 1'b0;
        n_cmp++; if (GNT !== 4'b0000) begin n_err++; $display("FAIL done_idle_gnt: got %b want 0000", GNT); end
        n_cmp++; if (BUSY !== 1'b0) begin n_err++; $display("FAIL done_idle_busy: got %b want 0", BUSY); end
        REQ = 4'b0001;
        #1;
        n_cmp++; if (ANY !== 1'b1) begin n_err++; $display("FAIL any_pulse: got %b want 1", ANY); end
        #1;
        REQ = 4'b0000;
        @(negedge C);
        n_cmp++; if (GNT !== 4'b0000) begin n_err++; $display("FAIL req_not_latched: got %b want 0000", GNT); end
    endtask

`ifdef ARB4_TIMEOUT_EN
    task automatic test_timeout;
        REQ  = 4'b0011;
        DONE = 1'b0;
        @(negedge C);
        n_cmp++; if (GNT !== 4'b0001) begin n_err++; $display("FAIL to_grant0: got %b want 0001", GNT); end
        for (int k = 0; k < 3; k++) begin
            @(negedge C);
            n_cmp++; if (GNT !== 4'b0001 || TO !== 1'b0) begin n_err++; $display("FAIL to_hold[%0d]: got gnt=%b to=%b want 0001/0", k, GNT, TO); end
        end
        @(negedge C);
        n_cmp++; if (GNT !== 4'b0000) begin n_err++; $display("FAIL to_forced_gnt: got %b want 0000", GNT); end
        n_cmp++; if (TO !== 1'b1) begin n_err++; $display("FAIL to_pulse: got %b want 1", TO); end
        @(negedge C);
        n_cmp++; if (TO !== 1'b0) begin n_err++; $display("FAIL to_pulse_end: got %b want 0", TO); end
        n_cmp++; if (GNT !== 4'b0010) begin n_err++; $display("FAIL to_next_gnt: got %b want 0010", GNT); end
        for (int k = 0; k < 3; k++) begin
            @(negedge C);
            n_cmp++; if (GNT !== 4'b0010 || TO !== 1'b0) begin n_err++; $display("FAIL to_hold1[%0d]: got gnt=%b to=%b want 0010/0", k, GNT, TO); end
        end
        DONE = 1'b1;
        @(negedge C);
        n_cmp++; if (GNT !== 4'b0000) begin n_err++; $display("FAIL to_tie_gnt: got %b want 0000", GNT); end
        n_cmp++; if (TO !== 1'b0) begin n_err++; $display("FAIL to_tie_normal_wins: got %b want 0", TO); end
        DONE = 1'b0;
        REQ  = 4'b0000;
        @(negedge C);
    endtask
`else
    task automatic test_timeout;
        REQ  = 4'b0001;
        DONE = 1'b0;
        @(negedge C);
        n_cmp++; if (GNT !== 4'b0001) begin n_err++; $display("FAIL hold_grant: got %b want 0001", GNT); end
        for (int k = 0; k < 20; k++) begin
            @(negedge C);
            n_cmp++; if (GNT !== 4'b0001 || TO !== 1'b0) begin n_err++; $display("FAIL hold_forever[%0d]: got gnt=%b to=%b want 0001/0", k, GNT, TO); end
        end
        DONE = 1'b1;
        REQ  = 4'b0000;
        @(negedge C);
        DONE = 1'b0;
        n_cmp++; if (GNT !== 4'b0000) begin n_err++; $display("FAIL hold_release: got %b want 0000", GNT); end
    endtask
`endif

    task automatic test_random;
        logic [3:0] prev_req;
        logic [3:0] prev_gnt;
        prev_req = REQ;
        prev_gnt = GNT;
        for (int cyc = 0; cyc < 10000; cyc++) begin
            @(negedge C);
            n_cmp++; if ((GNT & (GNT - 4'd1)) !== 4'd0) begin n_err++; $display("FAIL rand_onehot@%0d: got %b want one-hot or zero", cyc, GNT); end
            n_cmp++; if (BUSY !== (GNT != 4'd0)) begin n_err++; $display("FAIL rand_busy@%0d: got %b want %b", cyc, BUSY, GNT != 4'd0); end
            if (BUSY) begin
                n_cmp++; if (GNT !== (4'b0001 << GID)) begin n_err++; $display("FAIL rand_gid@%0d: got gid=%0d gnt=%b", cyc, GID, GNT); end
            end
            if (prev_gnt == 4'd0 && GNT != 4'd0) begin
                n_cmp++; if ((GNT & prev_req) === 4'd0) begin n_err++; $display("FAIL rand_idle_grant@%0d: got %b want subset of %b", cyc, GNT, prev_req); end
            end
            prev_gnt = GNT;
            REQ      = REQ ^ (4'($urandom_range(0, 15)) & 4'($urandom_range(0, 15)));
            DONE     = ($urandom_range(0, 7) == 0);
            prev_req = REQ;
            #1;
            n_cmp++; if (ANY !== (|REQ)) begin n_err++; $display("FAIL rand_any@%0d: got %b want %b", cyc, ANY, |REQ); end
        end
        REQ  = 4'b0000;
        DONE = 1'b0;
    endtask

    initial begin
        CLR  = 1'b1;
        REQ  = 4'b0000;
        DONE = 1'b0;
        test_reset();
        test_fairness();
        test_clr_mid_grant();
        test_single();
        test_done_plus_req();
        test_idle_inputs();
        test_timeout();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
